// File: rtl/fifo_sync_param.sv
// fifo_sync_param: single-clock FIFO with standard or fall-through read,
// occupancy count, programmable level flags and sticky error flags.
module fifo_sync_param #(
  parameter int DWIDTH    = 40,
  parameter int AWIDTH    = 8,
  parameter int FWFT      = 0,
  parameter int AF_THRESH = (1 << AWIDTH) - 2,
  parameter int AE_THRESH = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic [DWIDTH-1:0] din,
  input  logic              we,
  input  logic              re,
  output logic [DWIDTH-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              almost_full,
  output logic              almost_empty,
  output logic [AWIDTH:0]   count,
  output logic              overflow,
  output logic              underflow
);

  localparam int DEPTH = 1 << AWIDTH;
  localparam logic [AWIDTH:0] DEPTH_C = (AWIDTH+1)'(DEPTH);
  localparam logic [AWIDTH:0] AF_C = (AWIDTH+1)'(AF_THRESH);
  localparam logic [AWIDTH:0] AE_C = (AWIDTH+1)'(AE_THRESH);
  localparam logic [AWIDTH-1:0] PTR_ONE = {{(AWIDTH-1){1'b0}}, 1'b1};
  localparam logic [AWIDTH:0] CNT_ONE = {{AWIDTH{1'b0}}, 1'b1};

  logic [DWIDTH-1:0] mem_q [DEPTH];
  logic [DWIDTH-1:0] rd_data_q;

  logic [AWIDTH-1:0] wp_q, wp_d;
  logic [AWIDTH-1:0] rp_q, rp_d;
  logic [AWIDTH:0]   cnt_q, cnt_d;
  logic              ovf_q, ovf_d;
  logic              unf_q, unf_d;
  logic              mid_v_q, mid_v_d;
  logic              mid_byp_q, mid_byp_d;
  logic [DWIDTH-1:0] byp_q, byp_d;
  logic              out_v_q, out_v_d;
  logic [DWIDTH-1:0] out_q, out_d;

  logic              full_w, empty_w;
  logic              push, pop;
  logic              ram_we, ram_re;
  logic              out_ld, mid_free;
  logic [AWIDTH:0]   ram_n;
  logic [DWIDTH-1:0] mid_data;

  assign full_w  = (cnt_q == DEPTH_C);
  assign empty_w = (FWFT != 0) ? !out_v_q : (cnt_q == '0);
  assign push    = we && !full_w;
  assign pop     = re && !empty_w;

  // words committed to RAM but not yet fetched into the output pipeline
  assign ram_n = cnt_q
               - {{AWIDTH{1'b0}}, mid_v_q}
               - {{AWIDTH{1'b0}}, out_v_q};

  assign mid_data = mid_byp_q ? byp_q : rd_data_q;

  // next state: pointers, count, sticky flags and prefetch pipeline
  always_comb begin
    wp_d      = wp_q;
    rp_d      = rp_q;
    cnt_d     = cnt_q;
    ovf_d     = ovf_q;
    unf_d     = unf_q;
    mid_v_d   = mid_v_q;
    mid_byp_d = mid_byp_q;
    byp_d     = byp_q;
    out_v_d   = out_v_q;
    out_d     = out_q;
    ram_we    = 1'b0;
    ram_re    = 1'b0;
    out_ld    = 1'b0;
    mid_free  = 1'b0;
    if (rst || clr) begin
      wp_d      = '0;
      rp_d      = '0;
      cnt_d     = '0;
      ovf_d     = 1'b0;
      unf_d     = 1'b0;
      mid_v_d   = 1'b0;
      mid_byp_d = 1'b0;
      out_v_d   = 1'b0;
    end else begin
      if (we && full_w) ovf_d = 1'b1;
      if (re && empty_w) unf_d = 1'b1;
      if (push) begin
        ram_we = 1'b1;
        wp_d   = wp_q + PTR_ONE;
      end
      case ({push, pop})
        2'b10:   cnt_d = cnt_q + CNT_ONE;
        2'b01:   cnt_d = cnt_q - CNT_ONE;
        default: cnt_d = cnt_q;
      endcase
      if (FWFT == 0) begin
        if (pop) begin
          ram_re = 1'b1;
          rp_d   = rp_q + PTR_ONE;
        end
      end else begin
        out_ld = (!out_v_q || pop) && mid_v_q;
        if (out_ld) begin
          out_v_d = 1'b1;
          out_d   = mid_data;
        end else if (pop) begin
          out_v_d = 1'b0;
        end
        mid_free = !mid_v_q || out_ld;
        if (mid_free) begin
          if (ram_n != '0) begin
            ram_re    = 1'b1;
            rp_d      = rp_q + PTR_ONE;
            mid_v_d   = 1'b1;
            mid_byp_d = 1'b0;
          end else if (push && out_v_d) begin
            // a word written behind a live head skips the RAM
            // so the next pop sees it without a bubble
            rp_d      = rp_q + PTR_ONE;
            mid_v_d   = 1'b1;
            mid_byp_d = 1'b1;
            byp_d     = din;
          end else begin
            mid_v_d   = 1'b0;
          end
        end
      end
    end
  end

  // control and output-stage registers
  always_ff @(posedge clk) begin
    if (rst) begin
      wp_q      <= '0;
      rp_q      <= '0;
      cnt_q     <= '0;
      ovf_q     <= 1'b0;
      unf_q     <= 1'b0;
      mid_v_q   <= 1'b0;
      mid_byp_q <= 1'b0;
      byp_q     <= '0;
      out_v_q   <= 1'b0;
      out_q     <= '0;
    end else begin
      wp_q      <= wp_d;
      rp_q      <= rp_d;
      cnt_q     <= cnt_d;
      ovf_q     <= ovf_d;
      unf_q     <= unf_d;
      mid_v_q   <= mid_v_d;
      mid_byp_q <= mid_byp_d;
      byp_q     <= byp_d;
      out_v_q   <= out_v_d;
      out_q     <= out_d;
    end
  end

  // RAM write port; contents are never cleared
  always_ff @(posedge clk) begin
    if (ram_we) mem_q[wp_q] <= din;
  end

  // RAM registered read port
  always_ff @(posedge clk) begin
    if (rst) rd_data_q <= '0;
    else if (ram_re) rd_data_q <= mem_q[rp_q];
  end

  assign dout         = (FWFT != 0) ? out_q : rd_data_q;
  assign full         = full_w;
  assign empty        = empty_w;
  assign almost_full  = (cnt_q >= AF_C);
  assign almost_empty = (cnt_q <= AE_C);
  assign count        = cnt_q;
  assign overflow     = ovf_q;
  assign underflow    = unf_q;

endmodule

// File: tb/tb_fifo_sync_param.sv
// tb_fifo_sync_param: standard and fall-through instances driven together,
// checked each cycle against a queue-based reference model.
module tb_fifo_sync_param;

  typedef struct {
    logic [3:0] cnt;
    logic       emp;
    logic       ful;
    logic       af;
    logic       ae;
    logic       ovf;
    logic       unf;
    logic [7:0] dout;
  } exp_t;

  logic       clk;
  logic       rst, clr, we, re;
  logic [7:0] din;
  logic [7:0] dout_a [2];
  logic       full_a [2];
  logic       empty_a [2];
  logic       af_a [2];
  logic       ae_a [2];
  logic [3:0] count_a [2];
  logic       ovf_a [2];
  logic       unf_a [2];

  int checks = 0;
  int errors = 0;

  logic [7:0] mdq [2][$];
  int         mwq [2][$];
  bit         mvis [2];
  bit         movf [2];
  bit         munf [2];
  logic [7:0] mdout [2];
  int         medge = 0;
  exp_t       sbq [2][$];

  fifo_sync_param #(
    .DWIDTH(8), .AWIDTH(3), .FWFT(0)
  ) u_std (
    .clk(clk), .rst(rst), .clr(clr), .din(din),
    .we(we), .re(re), .dout(dout_a[0]),
    .full(full_a[0]), .empty(empty_a[0]),
    .almost_full(af_a[0]), .almost_empty(ae_a[0]),
    .count(count_a[0]), .overflow(ovf_a[0]),
    .underflow(unf_a[0])
  );

  fifo_sync_param #(
    .DWIDTH(8), .AWIDTH(3), .FWFT(1)
  ) u_fwft (
    .clk(clk), .rst(rst), .clr(clr), .din(din),
    .we(we), .re(re), .dout(dout_a[1]),
    .full(full_a[1]), .empty(empty_a[1]),
    .almost_full(af_a[1]), .almost_empty(ae_a[1]),
    .count(count_a[1]), .overflow(ovf_a[1]),
    .underflow(unf_a[1])
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic chk(input string nm, input int m,
                     input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s mode%0d got %h want %h t=%0t",
               nm, m, act, exp, $time);
    end
  endtask

  // Reference: FIFO is a queue of (data, write-edge). In fall-through
  // mode the head is shown once it was written two edges ago, or at
  // once when it follows a popped head (no bubble).
  task automatic model_edge(input bit r, input bit c, input bit w,
                            input bit rd, input logic [7:0] d);
    exp_t e;
    int   n;
    bit   rok, wok;
    logic [7:0] x;
    medge++;
    for (int m = 0; m < 2; m++) begin
      if (r || c) begin
        mdq[m].delete();
        mwq[m].delete();
        mvis[m] = 1'b0;
        movf[m] = 1'b0;
        munf[m] = 1'b0;
        if (r) mdout[m] = 8'h00;
      end else begin
        n   = mdq[m].size();
        rok = rd && ((m == 0) ? (n > 0) : mvis[m]);
        wok = w && (n < 8);
        if (rd && !rok) munf[m] = 1'b1;
        if (w && !wok) movf[m] = 1'b1;
        if (rok) begin
          x = mdq[m].pop_front();
          void'(mwq[m].pop_front());
          if (m == 0) mdout[m] = x;
        end
        if (wok) begin
          mdq[m].push_back(d);
          mwq[m].push_back(medge);
        end
        if (m == 1) begin
          mvis[m] = (mdq[m].size() > 0) &&
                    ((mwq[m][0] <= medge - 2) ||
                     ((mwq[m][0] == medge - 1) && rok));
          if (mvis[m]) mdout[m] = mdq[m][0];
        end
      end
      n      = mdq[m].size();
      e.cnt  = 4'(n);
      e.emp  = (m == 0) ? (n == 0) : !mvis[m];
      e.ful  = (n == 8);
      e.af   = (n >= 6);
      e.ae   = (n <= 2);
      e.ovf  = movf[m];
      e.unf  = munf[m];
      e.dout = mdout[m];
      sbq[m].push_back(e);
    end
  endtask

  task automatic step(input bit r, input bit c, input bit w,
                      input bit rd, input logic [7:0] d);
    rst = r;
    clr = c;
    we  = w;
    re  = rd;
    din = d;
    @(posedge clk);
    model_edge(r, c, w, rd, d);
    #1;
  endtask

  // monitor: compare everything the DUTs present against the model
  always @(negedge clk) begin
    exp_t e;
    for (int m = 0; m < 2; m++) begin
      if (sbq[m].size() > 0) begin
        e = sbq[m].pop_front();
        chk("count", m, 32'(count_a[m]), 32'(e.cnt));
        chk("empty", m, 32'(empty_a[m]), 32'(e.emp));
        chk("full", m, 32'(full_a[m]), 32'(e.ful));
        chk("almost_full", m, 32'(af_a[m]), 32'(e.af));
        chk("almost_empty", m, 32'(ae_a[m]), 32'(e.ae));
        chk("overflow", m, 32'(ovf_a[m]), 32'(e.ovf));
        chk("underflow", m, 32'(unf_a[m]), 32'(e.unf));
        chk("dout", m, 32'(dout_a[m]), 32'(e.dout));
      end
    end
  end

  initial begin
    int pw, pr;
    // fill to full, overflow, drain, underflow
    step(1, 0, 0, 0, 8'h00);
    for (int i = 1; i <= 8; i++) step(0, 0, 1, 0, 8'(i));
    step(0, 0, 1, 0, 8'hFF);
    step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 9; i++) step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // steady count 3 across pointer wrap
    step(1, 0, 0, 0, 8'h00);
    for (int i = 0; i < 3; i++) step(0, 0, 1, 0, 8'h10 + 8'(i));
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    for (int i = 0; i < 20; i++) step(0, 0, 1, 1, 8'($urandom));
    // fall-through latency and back-to-back pops
    step(1, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'hA5);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    step(0, 0, 1, 0, 8'hB6);
    step(0, 0, 1, 0, 8'hC7);
    for (int i = 0; i < 5; i++) step(0, 0, 0, 1, 8'h00);
    // clear with a write in the same cycle
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h40 + 8'(i));
    step(0, 0, 0, 0, 8'h00);
    step(0, 1, 1, 0, 8'h99);
    step(0, 0, 0, 1, 8'h00);
    step(0, 0, 0, 0, 8'h00);
    // reset mid-burst then resume
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h60 + 8'(i));
    for (int i = 0; i < 3; i++) step(0, 0, 1, 1, 8'h70 + 8'(i));
    step(1, 0, 1, 1, 8'h7F);
    for (int i = 0; i < 4; i++) step(0, 0, 1, 0, 8'h80 + 8'(i));
    for (int i = 0; i < 6; i++) step(0, 0, 0, 1, 8'h00);
    // randomized traffic with shifting fill pressure
    for (int seg = 0; seg < 10; seg++) begin
      pw = (seg % 2 == 0) ? 75 : 30;
      pr = (seg % 2 == 0) ? 35 : 80;
      for (int i = 0; i < 60; i++) begin
        step($urandom_range(199) == 0,
             $urandom_range(99) == 0,
             $urandom_range(99) < pw,
             $urandom_range(99) < pr,
             8'($urandom));
      end
    end
    step(0, 0, 0, 0, 8'h00);
    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/fifo_sync_param.md
Name: fifo_sync_param

Overview:
- Next-generation synchronous single-clock FIFO for the datapath buffering modules.
- Depth and width are parametrised.
- Adds the following to the basic guard-bit FIFO:
  - selectable standard or first-word-fall-through (FWFT) read mode
  - occupancy count
  - programmable almost-full and almost-empty flags
  - overflow/underflow protection with sticky error flags
- Storage is an inferred dual-port RAM with registered read: port A reads, port B writes.

Parameters:
DWIDTH, 40, data word width in bits (>=1)
AWIDTH, 8, address width; DEPTH = 1<<AWIDTH words (AWIDTH>=2)
FWFT, 0, 0 = standard read (data follows re), 1 = first-word-fall-through
AF_THRESH, (1<<AWIDTH)-2, almost_full asserted when count >= AF_THRESH
AE_THRESH, 2, almost_empty asserted when count <= AE_THRESH

Ports:
clk  input  1  clock; all logic on rising edge
rst  input  1  synchronous active-high reset
clr  input  1  synchronous clear of pointers, count and flags
din  input  DWIDTH  write data
we  input  1  write request
re  input  1  read request (in FWFT: pop of the displayed word)
dout  output  DWIDTH  read data
full  output  1  count == DEPTH
empty  output  1  no readable word (see FWFT rule)
almost_full  output  1  count >= AF_THRESH
almost_empty  output  1  count <= AE_THRESH
count  output  AWIDTH+1  words held, 0..DEPTH
overflow  output  1  sticky: write attempted while full
underflow  output  1  sticky: read attempted while empty

Behaviour:
- Priority at each edge: rst > clr > we/re.
- rst or clr: wp=rp=0, count=0, empty=1, full=0, almost_empty=1, almost_full=(AF_THRESH==0), overflow=underflow=0.
- rst also sets dout=0; clr leaves dout unchanged.
- RAM contents are never cleared.
- Mid-operation rst/clr discards all data; we/re in that cycle are ignored.
- Write is accepted iff we && !full. Accepted write: RAM[wp]<=din, wp<=wp+1 (mod DEPTH wrap).
- Read is accepted iff re && !empty. Accepted read: rp<=rp+1 (mod DEPTH wrap).
- Rejected we (full): no state change except overflow<=1.
- Rejected re (empty): no state change except underflow<=1.
- Write while full is rejected even if a read is accepted in the same cycle.
- Read while empty is rejected even if a write is accepted in the same cycle.
- Count update: +1 on write only, -1 on read only, unchanged on simultaneous accepted read and write.
- Count never wraps.
- full, almost_full, almost_empty and the FWFT=0 empty are combinational decodes of the count register. They are valid in the same cycle as count.
- FWFT=0 (standard mode):
  - empty = (count==0).
  - dout updates at the edge accepting a read, with the word at the old rp (1-cycle latency from re).
  - dout holds its value when no read is accepted.
  - The RAM read port is enabled only by an accepted read.
- FWFT=1 (fall-through mode):
  - The head word is prefetched into the output stage; empty = output stage not valid.
  - dout shows the head word whenever empty==0.
  - An accepted read (re && !empty) advances to the next word with no bubble when count>=2. dout is the new head after that edge.
  - Write to an empty FIFO at edge E0: empty deasserts and dout is valid after edge E2.
  - Count includes the word held in the output stage; total capacity is exactly DEPTH.
  - dout holds its last value while empty.
- No read-during-write hazard: the read port only addresses committed entries.
- overflow and underflow are cleared only by rst or clr.

Test Plan:
1. AWIDTH=3, FWFT=0: after rst, write 8 words 0x01..0x08 -> count 1..8; full=1 at count 8; almost_full=1 from count 6; empty=0 after the first write edge.
2. Full FIFO, we=1 din=0xFF for one cycle -> count stays 8, overflow=1 and stays 1. Read 8 -> dout 0x01..0x08, each one cycle after re. A 9th re -> underflow=1, dout holds 0x08.
3. Wrap-around: run 20 interleaved write/read pairs at count 3 with simultaneous we&re each cycle -> count constant 3, data order preserved across pointer wrap.
4. FWFT=1: single write 0xA5 at edge E0 -> empty=0 and dout=0xA5 after E2. Write 0xB6, 0xC7 then hold re=1 -> dout 0xA5, 0xB6, 0xC7 on consecutive cycles, then empty=1.
5. Half-full FIFO (count 4) + clr with we=1 -> count=0, empty=1, sticky flags 0, the write is ignored. Next read -> underflow=1.
6. Assert rst mid-burst with we=re=1 -> all outputs at reset values after that edge, dout=0. Normal operation resumes on the next cycle.
